// File: rtl/axis_wrr_if.sv
// AXI-stream bundle carrying N lanes side by side; lane i occupies slice i of each field.
// The arbiter takes the N-lane slave side in and drives a single-lane master side out.
interface axis_wrr_if #(
   parameter int N          = 1,
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = 8,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   logic [N*DATA_WIDTH-1:0] tdata;
   logic [N*KEEP_WIDTH-1:0] tkeep;
   logic [N-1:0]            tvalid;
   logic [N-1:0]            tready;
   logic [N-1:0]            tlast;
   logic [N*ID_WIDTH-1:0]   tid;
   logic [N*DEST_WIDTH-1:0] tdest;
   logic [N*USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_wrr_arb_mux.sv
// Weighted round-robin AXI-stream mux: frame-granular grants, per-source frame credit,
// and a two-entry skid buffer so s_axis_tready never depends on m_axis_tready.
//
// state  | meaning
// IDLE   | no grant; pick next requester at/after the pointer, load or keep credit
// ACTIVE | granted source streams one frame into the skid buffer until tlast
module axis_wrr_arb_mux #(
   parameter int S_COUNT      = 4,
   parameter int DATA_WIDTH   = 64,
   parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter bit ID_ENABLE    = 1'b1,
   parameter int ID_WIDTH     = 8,
   parameter bit DEST_ENABLE  = 1'b1,
   parameter int DEST_WIDTH   = 8,
   parameter bit USER_ENABLE  = 1'b1,
   parameter int USER_WIDTH   = 1,
   parameter int WEIGHT_WIDTH = 4,
   localparam int IDX_W       = $clog2(S_COUNT)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   axis_wrr_if.slave                       s_axis,
   input  logic [S_COUNT*WEIGHT_WIDTH-1:0] s_weight,
   axis_wrr_if.master                      m_axis,
   output logic [IDX_W-1:0]                grant_index,
   output logic                            grant_valid
);
   localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        grant_index_q, grant_index_d;
   logic                    grant_valid_q, grant_valid_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [BEAT_W-1:0]       head_q, head_d;
   logic [BEAT_W-1:0]       tail_q, tail_d;

   logic [S_COUNT-1:0]      req;
   logic [S_COUNT-1:0]      tready_w;
   logic                    pick_found;
   logic [IDX_W-1:0]        pick_idx, cand_idx, next_idx;
   logic [WEIGHT_WIDTH-1:0] pick_weight;
   logic                    sel_valid, sel_last, push, pop;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [KEEP_WIDTH-1:0]   sel_keep;
   logic [ID_WIDTH-1:0]     sel_id;
   logic [DEST_WIDTH-1:0]   sel_dest;
   logic [USER_WIDTH-1:0]   sel_user;
   logic [BEAT_W-1:0]       beat_in;

   // Disabled sideband fields are stored as constants so the head register drives them directly.
   always_comb begin
      sel_valid = s_axis.tvalid[grant_index_q];
      sel_last  = s_axis.tlast[grant_index_q];
      sel_data  = s_axis.tdata[int'(grant_index_q)*DATA_WIDTH +: DATA_WIDTH];
      sel_keep  = KEEP_ENABLE ? s_axis.tkeep[int'(grant_index_q)*KEEP_WIDTH +: KEEP_WIDTH] : '1;
      sel_id    = ID_ENABLE ? s_axis.tid[int'(grant_index_q)*ID_WIDTH +: ID_WIDTH] : '0;
      sel_dest  = DEST_ENABLE ? s_axis.tdest[int'(grant_index_q)*DEST_WIDTH +: DEST_WIDTH] : '0;
      sel_user  = USER_ENABLE ? s_axis.tuser[int'(grant_index_q)*USER_WIDTH +: USER_WIDTH] : '0;
      beat_in   = {sel_last, sel_user, sel_dest, sel_id, sel_keep, sel_data};
   end

   always_comb begin
      req        = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int i = 0; i < S_COUNT; i++)
         req[i] = s_axis.tvalid[i] && (s_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
      for (int i = 0; i < S_COUNT; i++) begin
         cand_idx = IDX_W'((int'(ptr_q) + i) % S_COUNT);
         if (!pick_found && req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
      pick_weight = s_weight[int'(pick_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      next_idx    = (grant_index_q == IDX_W'(S_COUNT - 1)) ? '0 : grant_index_q + 1'b1;
   end

   // Ready is derived only from registered state; a pop frees a slot one cycle later.
   always_comb begin
      tready_w = '0;
      if (state_q == ACTIVE && cnt_q != 2'd2)
         tready_w[grant_index_q] = 1'b1;
      push = (state_q == ACTIVE) && (cnt_q != 2'd2) && sel_valid;
      pop  = (cnt_q != 2'd0) && m_axis.tready[0];
   end

   always_comb begin
      state_d       = state_q;
      grant_index_d = grant_index_q;
      grant_valid_d = grant_valid_q;
      ptr_d         = ptr_q;
      credit_d      = credit_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d       = ACTIVE;
               grant_index_d = pick_idx;
               grant_valid_d = 1'b1;
               if (pick_idx != grant_index_q || credit_q == '0)
                  credit_d = pick_weight;
            end
         end
         ACTIVE: begin
            if (push && sel_last) begin
               state_d       = IDLE;
               grant_valid_d = 1'b0;
               credit_d      = (credit_q != '0) ? credit_q - 1'b1 : '0;
               ptr_d         = (credit_q <= WEIGHT_WIDTH'(1)) ? next_idx : grant_index_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = beat_in;
            else               tail_d = beat_in;
            cnt_d = cnt_q + 1'b1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 1'b1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) head_d = beat_in;
            else begin
               head_d = tail_q;
               tail_d = beat_in;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_index_q <= '0;
         grant_valid_q <= 1'b0;
         ptr_q         <= '0;
         credit_q      <= '0;
         cnt_q         <= 2'd0;
         head_q        <= '0;
         tail_q        <= '0;
      end else begin
         state_q       <= state_d;
         grant_index_q <= grant_index_d;
         grant_valid_q <= grant_valid_d;
         ptr_q         <= ptr_d;
         credit_q      <= credit_d;
         cnt_q         <= cnt_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
      end
   end

   assign s_axis.tready = tready_w;
   assign m_axis.tvalid = (cnt_q != 2'd0);
   assign {m_axis.tlast, m_axis.tuser, m_axis.tdest, m_axis.tid, m_axis.tkeep, m_axis.tdata} = head_q;
   assign grant_index   = grant_index_q;
   assign grant_valid   = grant_valid_q;
endmodule

// File: doc/axis_wrr_arb_mux.md
# axis_wrr_arb_mux

Weighted round-robin AXI-stream arbitrating multiplexer: merges S_COUNT frame-based input streams onto one output. A source keeps the grant until its frame's tlast, then may send further frames up to its runtime weight before the grant rotates. The output is registered through a two-entry skid buffer, so no ready path is combinational from m_axis_tready to s_axis_tready. It is the weighted successor to the fixed/priority/round-robin arbitrating mux, and sits in front of shared MAC TX paths and DMA-descriptor merges.

## Interface
- S_COUNT, 4, number of input streams (2..16)
- DATA_WIDTH, 64, tdata width
- KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep; when 0, m_axis_tkeep is all ones
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- ID_ENABLE / ID_WIDTH, 1 / 8, carry tid; when disabled, output is 0
- DEST_ENABLE / DEST_WIDTH, 1 / 8, carry tdest; when disabled, output is 0
- USER_ENABLE / USER_WIDTH, 1 / 1, carry tuser; when disabled, output is 0
- WEIGHT_WIDTH, 4, width of each per-source weight
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  S_COUNT×field width  concatenated inputs, source i in slice i
- s_weight  in  S_COUNT*WEIGHT_WIDTH  frames per turn for each source; 0 disables that source
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  field width  merged output
- grant_index  out  $clog2(S_COUNT)  source currently granted
- grant_valid  out  1  a grant is active

## Operation
- **FSM states:** IDLE, ACTIVE.
- **IDLE:**
  - Request vector: s_axis_tvalid[i] AND (s_weight[i] != 0).
  - Pick the first requester at or after the rotation pointer, wrapping modulo S_COUNT.
  - On a pick: register grant_index, set grant_valid=1 and go to ACTIVE.
  - If the picked source differs from the previous holder, or the previous holder's credit is exhausted, load its credit from s_weight. Otherwise keep the remaining credit.
  - With no requester, stay in IDLE.
- **ACTIVE:**
  - s_axis_tready[grant_index] = skid buffer has space. All other tready bits are 0.
  - Each accepted beat is written to the skid buffer unchanged.
- **End of frame** (accepted beat with tlast=1):
  - Decrement credit and go to IDLE; grant_valid drops the next cycle.
  - If credit becomes 0, the pointer moves to grant_index+1 (wraps).
  - If credit > 0, the pointer stays, so the same source wins again if it is still requesting.
  - If it is not requesting, the next requester after it wins; that source's credit is reloaded and the skipped source's remaining credit is discarded.
- **Weight sampling:** weights are sampled only at credit load. Changes mid-turn take effect on that source's next turn.
- **Credit counter:** WEIGHT_WIDTH bits and never underflows. The maximum weight 2^WEIGHT_WIDTH−1 gives that many frames.
- **Skid buffer:**
  - Two entries, FIFO order.
  - m_axis_* driven from the head register.
  - No beat is dropped or duplicated under any tready pattern.

## Timing
- **Reset** (async assert, sync release):
  - s_axis_tready=0, m_axis_tvalid=0, all m_axis data fields 0.
  - grant_index=0, grant_valid=0.
  - pointer=0, credit=0, skid buffer empty, FSM in IDLE.
- **Reset mid-frame:** the partial frame is abandoned and the output is cleared. After release, arbitration restarts at source 0.
- **Grant latency:** the first beat of a frame can be accepted 1 cycle after tvalid is seen in IDLE.
- **Frame gap:** exactly one idle input cycle between consecutive frames, including frames from the same source.
- **Data latency:** an accepted beat appears on m_axis 1 cycle later when the buffer is empty.
- **Throughput:** one beat/cycle inside a frame with m_axis_tready=1.
- **Backpressure:** with m_axis_tready=0, the buffer fills 2 beats. s_axis_tready drops in the cycle after the second fill; it depends only on registered state.
- **Simultaneous push and pop** on a full buffer: a pop frees a slot visible the next cycle, never combinationally.
- **tvalid during IDLE** for the current source is not accepted; only ACTIVE accepts beats.

## Test plan
- **Round-robin:** weights {1,1,1,1}, all sources sending 2-beat frames continuously, m_axis_tready=1 → output frame source order 0,1,2,3,0,1… and tid matches the source.
- **Weighted:** s_weight={0,0,1,3} (s3..s0) with s0 and s1 always requesting → order 0,0,0,1,0,0,0,1.
- **Disabled source:** s_weight[2]=0, only source 2 valid for 50 cycles → s_axis_tready[2]=0, m_axis_tvalid=0, grant_valid=0.
- **Early stop:** source 0 has weight 3 but stops after 1 frame, source 3 requesting → next grant is 3. Source 0's next turn carries credit 3 again.
- **Backpressure:** m_axis_tready random 50% on 16-beat frames from all sources → byte-exact order per frame, no loss/dup, tlast count = frames sent, s_axis_tready drops with the buffer full.
- **Reset:** assert rst_n=0 in beat 3 of a frame → all outputs 0 in the same cycle. After release with all sources valid, the first grant_index is 0.
